// File: rtl/cpu_defs.sv
// cpu_defs: shared fetch-stage constants, op encodings and branch-target helper
package cpu_defs;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10, BR_RSVD = 2'b11} br_op_e;
  typedef enum logic [1:0] {JMP_NONE = 2'b00, JMP_IMM = 2'b01, JMP_REG = 2'b10, JMP_RSVD = 2'b11} jmp_op_e;
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm16);
    return pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_npc_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register set with sync reset and enable
module ifid_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc8_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc8_o
);
  logic [31:0] instr_q, pc_q, pc8_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      pc8_q   <= RESET_PC + 32'd8;
    end else if (en) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc8_q   <= pc8_i;
    end
  end
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc8_o   = pc8_q;
endmodule

// File: rtl/fetch_npc_stage.sv
// fetch_npc_stage: PC register, next-PC mux (beq/bne/j/jal/jr, one delay slot) and IF/ID register
module fetch_npc_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_F,
  input  logic        zero,
  input  logic [1:0]  br_op,
  input  logic [1:0]  jmp_op,
  input  logic [31:0] real_RFRD1,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D
);
  logic [31:0] pc_q, pc_d;
  logic        taken;
  always_comb begin
    taken = (br_op == BR_BEQ && zero) || (br_op == BR_BNE && !zero);
    // jumps outrank branches so a decoder that asserts both still redirects deterministically
    pc_d  = jmp_op == JMP_REG ? (real_RFRD1 & ~32'd3) :
            jmp_op == JMP_IMM ? {pc_D[31:28], instr_D[25:0], 2'b00} :
            taken             ? br_target(pc_D, instr_D[15:0]) :
                                pc_q + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else if (!stall) pc_q <= pc_d;
  end
  assign pc_F = pc_q;
  ifid_reg #(.RESET_PC(RESET_PC)) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .en      (!stall),
    .instr_i (instr_F),
    .pc_i    (pc_q),
    .pc8_i   (pc_q + 32'd8),
    .instr_o (instr_D),
    .pc_o    (pc_D),
    .pc8_o   (pc8_D)
  );
endmodule
